pipelined_prefix_adder: RTL

- Parametrised successor to the carry-lookahead prefix adder path: a full WIDTH-bit add/subtract built on a group generate/propagate stage, a Brent-Kung prefix tree over WIDTH/GROUPSIZE groups, and a sum stage.
- Three register stages with a valid/ready handshake on each side.
- Sits between the ALU operand mux and the writeback mux; carries an opaque tag for result routing.

---
 rtl/pipelined_prefix_adder_if.sv | 43 ++++
 rtl/pipelined_prefix_adder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_prefix_adder_if.sv
// Handshake bus for pipelined_prefix_adder.
// Input side:  in_valid/in_ready with operands in_a, in_b, in_sub, in_cin and in_tag.
// Output side: out_valid/out_ready with out_sum, out_cout, out_ovf and out_tag.
// Optional macro PREFIX_ADDER_FLAGS_EN adds out_zero and out_neg.
// modport master: the producer/consumer around the adder. modport slave: the adder.
interface pipelined_prefix_adder_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             in_cin;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic [TAG_W-1:0] out_tag;
`ifdef PREFIX_ADDER_FLAGS_EN
    logic             out_zero;
    logic             out_neg;
`endif

    modport master (
        output in_valid, in_a, in_b, in_sub, in_cin, in_tag, out_ready,
`ifdef PREFIX_ADDER_FLAGS_EN
        input  out_zero, out_neg,
`endif
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_cin, in_tag, out_ready,
`ifdef PREFIX_ADDER_FLAGS_EN
        output out_zero, out_neg,
`endif
        output in_ready, out_valid, out_sum, out_cout, out_ovf, out_tag
    );
endinterface

// File: rtl/pipelined_prefix_adder.sv
// Three-stage pipelined WIDTH-bit add/subtract:
//   S1 group generate/propagate, S2 Brent-Kung prefix over group pairs, S3 in-group ripple + sum.
// Ports: clk (rising edge), rst (async, active-high),
//        bus (pipelined_prefix_adder_if.slave): in_* operand handshake, out_* result handshake.
// Optional macro PREFIX_ADDER_FLAGS_EN adds registered out_zero/out_neg result flags.
// WIDTH must be a multiple of GROUPSIZE and WIDTH/GROUPSIZE a power of two >= 4.
module pipelined_prefix_adder #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned GROUPSIZE = 4,
    parameter int unsigned TAG_W     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    pipelined_prefix_adder_if.slave bus
);
    localparam int unsigned NG  = WIDTH / GROUPSIZE;
    localparam int unsigned LVL = $clog2(NG);

    // Stage valids and load enables; an empty stage always loads so bubbles collapse.
    logic r_v1, r_v2, r_v3;
    logic w_ld1, w_ld2, w_ld3, w_acc1;

    assign w_ld3        = !r_v3 || bus.out_ready;
    assign w_ld2        = !r_v2 || w_ld3;
    assign w_ld1        = !r_v1 || w_ld2;
    assign w_acc1       = bus.in_valid && w_ld1;
    assign bus.in_ready = w_ld1;

    // ---------------- S1: operand conditioning and group (G,P) ----------------
    logic [WIDTH-1:0] w_b_eff, w_p, w_g;
    logic             w_cin;
    logic [2*NG-1:0]  w_gp;

    assign w_b_eff = bus.in_sub ? ~bus.in_b : bus.in_b;
    assign w_cin   = bus.in_sub | bus.in_cin;
    assign w_p     = bus.in_a ^ w_b_eff;
    assign w_g     = bus.in_a & w_b_eff;

    // Per-group (G,P); pair k at [2k+1:2k] with G in the upper bit.
    always_comb begin : group_gp
        logic l_g, l_p;
        l_g  = 1'b0;
        l_p  = 1'b0;
        w_gp = '0;
        for (int k = 0; k < int'(NG); k++) begin
            l_g = 1'b0;
            l_p = 1'b1;
            for (int j = 0; j < int'(GROUPSIZE); j++) begin
                l_g = w_g[k*GROUPSIZE+j] | (w_p[k*GROUPSIZE+j] & l_g);
                l_p = l_p & w_p[k*GROUPSIZE+j];
            end
            w_gp[2*k +: 2] = {l_g, l_p};
        end
    end

    logic [WIDTH-1:0] r_p1, r_g1;
    logic [2*NG-1:0]  r_gp1;
    logic             r_cin1, r_a_msb1, r_b_msb1;
    logic [TAG_W-1:0] r_tag1;

    // Only the operand MSBs are needed past S1 (for overflow).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1     <= 1'b0;
            r_p1     <= '0;
            r_g1     <= '0;
            r_gp1    <= '0;
            r_cin1   <= 1'b0;
            r_a_msb1 <= 1'b0;
            r_b_msb1 <= 1'b0;
            r_tag1   <= '0;
        end else begin
            if (w_ld1) r_v1 <= bus.in_valid;
            if (w_acc1) begin
                r_p1     <= w_p;
                r_g1     <= w_g;
                r_gp1    <= w_gp;
                r_cin1   <= w_cin;
                r_a_msb1 <= bus.in_a[WIDTH-1];
                r_b_msb1 <= w_b_eff[WIDTH-1];
                r_tag1   <= bus.in_tag;
            end
        end
    end

    // ---------------- S2: Brent-Kung prefix over groups ----------------
    logic [NG-1:0] w_c;

    // In-place up-sweep then down-sweep; node k ends holding the prefix over groups 0..k.
    always_comb begin : prefix_tree
        logic [NG-1:0] l_g, l_p;
        l_g = '0;
        l_p = '0;
        for (int k = 0; k < int'(NG); k++) begin
            l_g[k] = r_gp1[2*k+1];
            l_p[k] = r_gp1[2*k];
        end
        l_g[0] = l_g[0] | (l_p[0] & r_cin1);
        for (int d = 0; d < int'(LVL); d++) begin
            for (int k = (2 << d) - 1; k < int'(NG); k += (2 << d)) begin
                l_g[k] = l_g[k] | (l_p[k] & l_g[k-(1<<d)]);
                l_p[k] = l_p[k] & l_p[k-(1<<d)];
            end
        end
        for (int d = int'(LVL) - 2; d >= 0; d--) begin
            for (int k = 3 * (1 << d) - 1; k < int'(NG); k += (2 << d)) begin
                l_g[k] = l_g[k] | (l_p[k] & l_g[k-(1<<d)]);
                l_p[k] = l_p[k] & l_p[k-(1<<d)];
            end
        end
        // Carry into group k is the prefix carry out of group k-1; group 0 takes cin.
        w_c = {l_g[NG-2:0], r_cin1};
    end

    logic [WIDTH-1:0] r_p2, r_g2;
    logic [NG-1:0]    r_c2;
    logic             r_a_msb2, r_b_msb2;
    logic [TAG_W-1:0] r_tag2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v2     <= 1'b0;
            r_p2     <= '0;
            r_g2     <= '0;
            r_c2     <= '0;
            r_a_msb2 <= 1'b0;
            r_b_msb2 <= 1'b0;
            r_tag2   <= '0;
        end else begin
            if (w_ld2) r_v2 <= r_v1;
            if (w_ld2 && r_v1) begin
                r_p2     <= r_p1;
                r_g2     <= r_g1;
                r_c2     <= w_c;
                r_a_msb2 <= r_a_msb1;
                r_b_msb2 <= r_b_msb1;
                r_tag2   <= r_tag1;
            end
        end
    end

    // ---------------- S3: in-group ripple and sum ----------------
    logic [WIDTH-1:0] w_sum;
    logic             w_cout, w_ovf;

    always_comb begin : group_ripple
        logic l_carry;
        l_carry = 1'b0;
        w_sum   = '0;
        for (int k = 0; k < int'(NG); k++) begin
            l_carry = r_c2[k];
            for (int j = 0; j < int'(GROUPSIZE); j++) begin
                w_sum[k*GROUPSIZE+j] = r_p2[k*GROUPSIZE+j] ^ l_carry;
                l_carry = r_g2[k*GROUPSIZE+j] | (r_p2[k*GROUPSIZE+j] & l_carry);
            end
        end
        // Ripple out of the top group is the adder carry-out.
        w_cout = l_carry;
    end

    assign w_ovf = (r_a_msb2 == r_b_msb2) && (w_sum[WIDTH-1] != r_a_msb2);

    logic [WIDTH-1:0] r_sum;
    logic             r_cout, r_ovf;
    logic [TAG_W-1:0] r_tag3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v3   <= 1'b0;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_tag3 <= '0;
        end else begin
            if (w_ld3) r_v3 <= r_v2;
            if (w_ld3 && r_v2) begin
                r_sum  <= w_sum;
                r_cout <= w_cout;
                r_ovf  <= w_ovf;
                r_tag3 <= r_tag2;
            end
        end
    end

    assign bus.out_valid = r_v3;
    assign bus.out_sum   = r_sum;
    assign bus.out_cout  = r_cout;
    assign bus.out_ovf   = r_ovf;
    assign bus.out_tag   = r_tag3;

`ifdef PREFIX_ADDER_FLAGS_EN
    // Result flags share S3's load/hold behaviour.
    logic r_zero, r_neg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
        end else if (w_ld3 && r_v2) begin
            r_zero <= (w_sum == '0);
            r_neg  <= w_sum[WIDTH-1];
        end
    end

    assign bus.out_zero = r_zero;
    assign bus.out_neg  = r_neg;
`endif
endmodule
